// File: rtl/beer_keg.sv
// Keg model for the beer dispenser: drains while the tap is open, refills on request.
// Optional sticky dry-tap flag (`dry_pour`) is built when KEG_DRY_POUR_EN is defined.
module beer_keg #(
  parameter int unsigned LEVEL_W       = 4,
  parameter int unsigned FULL_LEVEL    = 15,
  parameter int unsigned POUR_DIV      = 8,
  parameter int unsigned REFILL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               beer,
  input  logic               refill_req,
  output logic [LEVEL_W-1:0] beer_level,
  output logic               empty,
  output logic               refill_busy,
  output logic [7:0]         pour_count
`ifdef KEG_DRY_POUR_EN
  ,
  output logic               dry_pour
`endif
);

  localparam int unsigned DivW  = (POUR_DIV > 1) ? $clog2(POUR_DIV) : 1;
  localparam int unsigned StepW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

  localparam logic [LEVEL_W-1:0] FullLvl  = LEVEL_W'(FULL_LEVEL);
  localparam logic [LEVEL_W-1:0] OneLvl   = LEVEL_W'(1);
  localparam logic [DivW-1:0]    DivLast  = DivW'(POUR_DIV - 1);
  localparam logic [StepW-1:0]   StepLast = StepW'(REFILL_CYCLES - 1);

  typedef enum logic [1:0] {StServe, StEmpty, StRefill} state_e;

  state_e             state_q;
  logic [LEVEL_W-1:0] level_q;
  logic               empty_q;
  logic               busy_q;
  logic [7:0]         pours_q;
  logic [DivW-1:0]    div_q;
  logic [StepW-1:0]   step_q;
  logic               beer_prev_q;
`ifdef KEG_DRY_POUR_EN
  logic               dry_q;
`endif

  logic refill_ok;
  logic pour_start;

  assign refill_ok  = (state_q != StRefill) && refill_req && (level_q != FullLvl);
  assign pour_start = (state_q == StServe) && beer && !beer_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StServe;
      level_q     <= FullLvl;
      empty_q     <= 1'b0;
      busy_q      <= 1'b0;
      pours_q     <= 8'd0;
      div_q       <= '0;
      step_q      <= '0;
      beer_prev_q <= 1'b0;
`ifdef KEG_DRY_POUR_EN
      dry_q       <= 1'b0;
`endif
    end else begin
      beer_prev_q <= beer;
      if (pour_start && (pours_q != 8'hff)) begin
        pours_q <= pours_q + 8'd1;
      end

      if (refill_ok) begin
        // Refill wins over a same-edge tap cycle, which is discarded.
        state_q <= StRefill;
        busy_q  <= 1'b1;
        div_q   <= '0;
        step_q  <= '0;
`ifdef KEG_DRY_POUR_EN
        dry_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          StServe: begin
            if (beer) begin
              if (div_q == DivLast) begin
                div_q <= '0;
                if (level_q != '0) begin
                  level_q <= level_q - OneLvl;
                end
                if (level_q <= OneLvl) begin
                  state_q <= StEmpty;
                  empty_q <= 1'b1;
                end
              end else begin
                div_q <= div_q + 1'b1;
              end
            end
          end
          StEmpty: begin
`ifdef KEG_DRY_POUR_EN
            if (beer) begin
              dry_q <= 1'b1;
            end
`endif
          end
          StRefill: begin
            if (step_q == StepLast) begin
              step_q  <= '0;
              empty_q <= 1'b0;
              if (level_q != FullLvl) begin
                level_q <= level_q + OneLvl;
              end
              if (level_q >= FullLvl - OneLvl) begin
                state_q <= StServe;
                busy_q  <= 1'b0;
              end
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
          default: state_q <= StServe;
        endcase
      end
    end
  end

  assign beer_level  = level_q;
  assign empty       = empty_q;
  assign refill_busy = busy_q;
  assign pour_count  = pours_q;
`ifdef KEG_DRY_POUR_EN
  assign dry_pour    = dry_q;
`endif

endmodule

// File: tb/tb_beer_keg.sv
// Scoreboard bench for beer_keg: driver updates a behavioural keg model and queues the
// expected outputs each edge; a negedge monitor pops and compares.
module tb_beer_keg;

  localparam int unsigned LW   = 4;
  localparam int          FULL = 15;
  localparam int          PD   = 8;
  localparam int          RC   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          beer;
  logic          refill_req;
  logic [LW-1:0] beer_level;
  logic          empty;
  logic          refill_busy;
  logic [7:0]    pour_count;
`ifdef KEG_DRY_POUR_EN
  logic          dry_pour;
`endif

  beer_keg #(
    .LEVEL_W      (LW),
    .FULL_LEVEL   (FULL),
    .POUR_DIV     (PD),
    .REFILL_CYCLES(RC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .beer       (beer),
    .refill_req (refill_req),
    .beer_level (beer_level),
    .empty      (empty),
    .refill_busy(refill_busy),
    .pour_count (pour_count)
`ifdef KEG_DRY_POUR_EN
    ,
    .dry_pour   (dry_pour)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int level;
    bit empty;
    bit busy;
    int pc;
    bit dry;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Behavioural keg: refill level is derived from elapsed time since acceptance.
  int m_level, m_taps, m_pours, m_rstart, m_relap;
  bit m_ref, m_prev, m_dry;

  task automatic model_step(input bit b, input bit r, input bit rst);
    bit serving;
    bit dry_state;
    if (rst) begin
      m_level = FULL; m_ref = 0; m_taps = 0; m_pours = 0; m_prev = 0; m_dry = 0;
      return;
    end
    serving   = !m_ref && (m_level != 0);
    dry_state = !m_ref && (m_level == 0);
    if (serving && b && !m_prev && m_pours < 255) m_pours++;
    m_prev = b;
    if (m_ref) begin
      m_relap++;
      m_level = m_rstart + m_relap / RC;
      if (m_level >= FULL) begin
        m_level = FULL;
        m_ref   = 0;
      end
    end else if (r && m_level != FULL) begin
      m_ref = 1; m_rstart = m_level; m_relap = 0; m_taps = 0; m_dry = 0;
    end else if (serving && b) begin
      m_taps++;
      if (m_taps == PD) begin
        m_taps = 0;
        m_level--;
      end
    end else if (dry_state && b) begin
      m_dry = 1;
    end
  endtask

  task automatic cyc(input bit b, input bit r, input bit rst);
    exp_t e;
    beer = b; refill_req = r; reset = rst;
    @(posedge clk);
    model_step(b, r, rst);
    e.level = m_level; e.empty = (m_level == 0); e.busy = m_ref; e.pc = m_pours; e.dry = m_dry;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, ncyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("beer_level", int'(beer_level), mon_e.level);
      chk("empty", int'(empty), int'(mon_e.empty));
      chk("refill_busy", int'(refill_busy), int'(mon_e.busy));
      chk("pour_count", int'(pour_count), mon_e.pc);
`ifdef KEG_DRY_POUR_EN
      chk("dry_pour", int'(dry_pour), int'(mon_e.dry));
`endif
    end
  end

  initial begin
    int dens;
    bit b, r, rst;
    beer = 0; refill_req = 0; reset = 1;
    // Reset, then whole-unit pour and idle hold.
    repeat (2) cyc(0, 0, 1);
    repeat (8) cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    // Partial pours accumulate across openings.
    cyc(0, 0, 1);
    repeat (3) cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    repeat (5) cyc(1, 0, 0);
    // Full drain and taps on an empty keg.
    cyc(0, 0, 1);
    repeat (125) cyc(1, 0, 0);
    // Refill from empty with the tap held open.
    cyc(1, 1, 0);
    repeat (65) cyc(1, 0, 0);
    // Drain to 7, start refilling, reset mid-refill, then refill request at full.
    repeat (64) cyc(1, 0, 0);
    cyc(0, 1, 0);
    repeat (2) cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    // Tap held through reset release counts as a pour.
    cyc(1, 0, 1);
    repeat (4) cyc(1, 0, 0);
    // Randomized traffic with varying tap density.
    dens = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) dens = int'($urandom_range(1, 3));
      b   = (($urandom % 4) < dens);
      r   = ($urandom % 24 == 0);
      rst = ($urandom % 700 == 0);
      cyc(b, r, rst);
    end
    cyc(0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beer_keg.md
# beer_keg

Synthesizable keg model for the responder side of the beer dispenser interface. It consumes the tap-open output `beer` of `beer_draft_top` and produces the `beer_level` that `beer_draft_top` reads. This closes the loop so the dispenser can run on the board, or in a bench, without a hand-driven level. Level drains while the tap is open, and a refill request restores it over time.

## Interface

**Parameters**
- `LEVEL_W`, 4: width of `beer_level`.
- `FULL_LEVEL`, 15: level after reset and after a completed refill; must be ≤ 2^LEVEL_W−1 and ≥ 1.
- `POUR_DIV`, 8: tap-open cycles per level unit drained; ≥ 1.
- `REFILL_CYCLES`, 4: cycles per level unit restored during refill; ≥ 1.

**Ports**
- `clk` input 1: clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `beer` input 1: tap open, from `beer_draft_top`.
- `refill_req` input 1: refill request, sampled every edge.
- `beer_level` output LEVEL_W: current keg level, to `beer_draft_top`.
- `empty` output 1: high when level is 0.
- `refill_busy` output 1: high while refilling.
- `pour_count` output 8: number of pours started, saturating.
- `dry_pour` output 1: sticky dry-tap flag; exists only with `KEG_DRY_POUR_EN`.

One clock; reset is synchronous and active-high.

## Operation

**States**

SERVE, EMPTY, REFILL.

**Reset values**
- `beer_level`=FULL_LEVEL, `empty`=0, `refill_busy`=0, `pour_count`=0, `dry_pour`=0.
- Pour divider=0, refill step counter=0, state SERVE.

**SERVE**
- Each edge with `beer`=1 increments the pour divider.
- On the edge where the divider equals POUR_DIV−1 and `beer`=1:
  - `beer_level` decrements and the divider clears.
  - If the new level is 0, go to EMPTY and set `empty`=1 on the same edge.
- When `beer`=0 the divider holds; partial pours accumulate across tap openings.

**EMPTY**
- `beer` is ignored: no level change, divider held at 0.

**Refill acceptance**
- Accepted in SERVE or EMPTY when `refill_req`=1 and `beer_level`≠FULL_LEVEL.
- Next state is REFILL, with `refill_busy`=1, pour divider cleared, step counter cleared.
- `refill_req` has priority over `beer` on the same edge; that `beer` cycle does not count toward the divider.
- `refill_req` while already full is ignored.

**REFILL**
- Step counter increments each edge. When it reaches REFILL_CYCLES−1, `beer_level` increments, the counter clears, and `empty` deasserts.
- When the level reaches FULL_LEVEL: go to SERVE and `refill_busy`=0 on the same edge.
- `beer` and `refill_req` are ignored in this state.

**pour_count**
- Increments on each 0→1 transition of `beer` sampled while in SERVE.
- Saturates at 255.
- `beer` history register resets to 0, so a `beer` held high through reset release counts as one pour.

**Level arithmetic**
- Unsigned, LEVEL_W bits.
- Never decrements below 0 and never increments above FULL_LEVEL; no wrap-around.

## Timing

- All outputs are registered, with no combinational input-to-output paths.
- Drain latency: with a full keg and `beer` held high, the level drops on the POUR_DIV-th edge, then every POUR_DIV edges.
- Full drain from FULL_LEVEL takes FULL_LEVEL×POUR_DIV tap-open edges.
- Refill latency: first increment REFILL_CYCLES edges after acceptance. A refill from level L completes (FULL_LEVEL−L)×REFILL_CYCLES edges after the accepting edge.
- `reset` overrides everything on the edge it is sampled, including mid-pour and mid-refill. All outputs take reset values one edge later.

## Configuration

- `KEG_DRY_POUR_EN` defined:
  - `dry_pour` port present.
  - Set on any edge with `beer`=1 while in EMPTY.
  - Stays set until a refill is accepted or reset.
- Not defined:
  - Port and logic absent.
  - `beer` in EMPTY is silently ignored.

## Test plan

Defaults apply: FULL_LEVEL=15, POUR_DIV=8, REFILL_CYCLES=4.

1. Reset held 2 cycles → `beer_level`=15, `empty`=0, `refill_busy`=0, `pour_count`=0.
2. `beer` high 8 cycles → level 14 after 8th edge, `pour_count`=1; `beer` low 10 cycles → level stays 14.
3. `beer` high 3, low 5, high 5 → level drops 15→14 on the 5th edge of the second opening; `pour_count`=2.
4. `beer` held 120 cycles from full → level 0 and `empty`=1 at edge 120. Further `beer` gives no change. With `KEG_DRY_POUR_EN`, `dry_pour`=1 on edge 121.
5. `refill_req` pulse from empty with `beer` high throughout:
   - `refill_busy`=1 next edge.
   - Level 1 after 4 edges, `empty`=0.
   - Level 15 and `refill_busy`=0 after 60 edges.
   - `dry_pour` cleared at acceptance.
6. Reset asserted while refilling at level 7 → next edge level 15, `refill_busy`=0, `pour_count`=0. `refill_req` at full → ignored, `refill_busy` stays 0.
